// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous frame-buffer RAM between
// the VGA scan-out fetch and a pixel writer. Fetches land on fixed slots
// (one per upscaled pixel); the writer gets every other memory cycle.
// Sync and blank are delayed so they leave aligned with the fetched pixel.
module vga_fb_arbiter #(
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 15,
    parameter int PIX_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       h_pos,
    input  logic [15:0]       v_pos,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              display_on_in,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              blank_n,
    output logic              frame_start
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [15:0]       H_ACT     = 16'(H_ACTIVE);
    localparam logic [15:0]       V_ACT     = 16'(V_ACTIVE);
    localparam logic [ADDR_W:0]   FB_PIXELS = (ADDR_W + 1)'(FB_WIDTH * FB_HEIGHT);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [ADDR_W-1:0]   w_nextAddr;
    logic [PIX_W-1:0]    r_memWdata;
    logic [PIX_W-1:0]    w_nextWdata;
    logic                r_wrErr;
    logic                w_nextErr;
    logic                r_readValid;
    logic [PIX_W-1:0]    r_pixel;
    logic [1:0]          r_hSyncPipe;
    logic [1:0]          r_vSyncPipe;
    logic [1:0]          r_blankPipe;
    logic                r_frameStart;

    logic                w_fetchSlot;
    logic [ADDR_W-1:0]   w_fetchAddr;
    logic                w_inRange;
    logic                w_respBusy;

    // A slot is the first screen column of each upscaled frame-buffer pixel.
    assign w_fetchSlot = (h_pos < H_ACT) && (v_pos < V_ACT) &&
                         (h_pos[SCALE_SHIFT-1:0] == '0);
    assign w_fetchAddr = ADDR_W'(32'(v_pos >> SCALE_SHIFT) * FB_WIDTH +
                                 32'(h_pos >> SCALE_SHIFT));
    assign w_inRange   = {1'b0, wr_addr} < FB_PIXELS;
    // A request still high while its ack/err is showing is the old request.
    assign w_respBusy  = (r_state == WRITE) || r_wrErr;

    // Next-state and next memory-port values: fetch first, then the writer.
    always_comb begin
        w_nextState = IDLE;
        w_nextAddr  = r_memAddr;
        w_nextWdata = r_memWdata;
        w_nextErr   = 1'b0;
        if (w_fetchSlot) begin
            w_nextState = FETCH;
            w_nextAddr  = w_fetchAddr;
        end else if (wr_req && !w_respBusy) begin
            if (w_inRange) begin
                w_nextState = WRITE;
                w_nextAddr  = wr_addr;
                w_nextWdata = wr_data;
            end else begin
                w_nextErr = 1'b1;
            end
        end
    end

    // State register together with the registered memory-port fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_wrErr    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_memAddr  <= w_nextAddr;
            r_memWdata <= w_nextWdata;
            r_wrErr    <= w_nextErr;
        end
    end

    // Catch read data the cycle after a FETCH and hold it for the whole pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readValid <= 1'b0;
            r_pixel     <= '0;
        end else begin
            r_readValid <= (r_state == FETCH);
            if (r_readValid) begin
                r_pixel <= mem_rdata;
            end
        end
    end

    // Free-running two-stage delay for sync/blank plus the frame-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hSyncPipe  <= '0;
            r_vSyncPipe  <= '0;
            r_blankPipe  <= '0;
            r_frameStart <= 1'b0;
        end else begin
            r_hSyncPipe  <= {r_hSyncPipe[0], h_sync_in};
            r_vSyncPipe  <= {r_vSyncPipe[0], v_sync_in};
            r_blankPipe  <= {r_blankPipe[0], display_on_in};
            r_frameStart <= (h_pos == 16'd0) && (v_pos == 16'd0);
        end
    end

    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign mem_we      = (r_state == WRITE);
    assign wr_ack      = (r_state == WRITE);
    assign wr_err      = r_wrErr;
    assign h_sync_out  = r_hSyncPipe[1];
    assign v_sync_out  = r_vSyncPipe[1];
    assign blank_n     = r_blankPipe[1];
    assign frame_start = r_frameStart;
    assign pixel_data  = r_blankPipe[1] ? r_pixel : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for the frame-buffer arbiter with a
// simple timing generator, a writer that holds requests until acked, a
// synchronous RAM, and a cycle-history model compared on every cycle.
module tb_vga_fb_arbiter;

    localparam int M = 8191;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] h_pos = '0;
    logic [15:0] v_pos = '0;
    logic        h_sync_in = 1'b0;
    logic        v_sync_in = 1'b0;
    logic        display_on_in = 1'b0;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic        wr_err;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel_data;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        blank_n;
    logic        frame_start;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .display_on_in(display_on_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel_data(pixel_data), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .blank_n(blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM: read-first, data valid one cycle after the address.
    logic [7:0] ram [0:32767];
    logic [7:0] shadow [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]    = 8'(i * 37 + 11);
            shadow[i] = 8'(i * 37 + 11);
        end
        ram[0]    = 8'hE3;
        shadow[0] = 8'hE3;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus side: timing-generator position and a queue of pending writes.
    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wq[$];
    int  gh = 0;
    int  gv = 0;
    bit  prevDisp = 1'b0;

    task automatic applyStimulus(input bit rstV);
        @(posedge clk);
        #1;
        rst           = rstV;
        h_pos         = 16'(gh);
        v_pos         = 16'(gv);
        display_on_in = prevDisp;
        h_sync_in     = !(gh >= 656 && gh < 752);
        v_sync_in     = !(gv >= 490 && gv < 492);
        if (wq.size() > 0) begin
            wr_req  = 1'b1;
            wr_addr = wq[0].a;
            wr_data = wq[0].d;
        end else begin
            wr_req = 1'b0;
        end
        prevDisp = (gh < 640) && (gv < 480);
        gh++;
        if (gh == 800) begin
            gh = 0;
            gv++;
            if (gv == 525) gv = 0;
        end
        if (wr_req && (wr_ack || wr_err)) void'(wq.pop_front());
    endtask

    // Model: per-cycle input history; expectations derived from earlier cycles.
    bit          rstH   [0:M];
    bit [15:0]   hH     [0:M];
    bit [15:0]   vH     [0:M];
    bit          hsH    [0:M];
    bit          vsH    [0:M];
    bit          dispH  [0:M];
    bit          reqH   [0:M];
    bit [14:0]   addrH  [0:M];
    bit [7:0]    dataH  [0:M];
    bit          slotH  [0:M];
    bit          fetchH [0:M];
    bit          ackH   [0:M];
    bit          errH   [0:M];
    bit [7:0]    fvalH  [0:M];
    logic [14:0] heldAddr = '0;
    logic [7:0]  heldPix = '0;

    function automatic bit clean(input int k, input int t);
        for (int i = k; i <= t; i++) if (rstH[i & M]) return 1'b0;
        return 1'b1;
    endfunction

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin : modelCompare
        int t, p1, p2;
        bit eFetch, eAck, eErr, eBlank, eHs, eVs, eFs;
        logic [7:0] ePix;
        t  = cyc;
        p1 = (t - 1) & M;
        p2 = (t - 2) & M;
        rstH[t & M]  = rst;
        hH[t & M]    = h_pos;
        vH[t & M]    = v_pos;
        hsH[t & M]   = h_sync_in;
        vsH[t & M]   = v_sync_in;
        dispH[t & M] = display_on_in;
        reqH[t & M]  = wr_req;
        addrH[t & M] = wr_addr;
        dataH[t & M] = wr_data;
        slotH[t & M] = !rst && (h_pos < 16'd640) && (v_pos < 16'd480) && (h_pos % 16'd4 == 16'd0);
        eFetch = 1'b0;
        eAck   = 1'b0;
        eErr   = 1'b0;
        fvalH[t & M] = '0;
        if (t >= 3) begin
            if (clean(t - 1, t)) begin
                eFetch = slotH[p1];
                if (!slotH[p1] && reqH[p1] && !ackH[p1] && !errH[p1]) begin
                    if (int'(addrH[p1]) < 160 * 120) eAck = 1'b1;
                    else eErr = 1'b1;
                end
            end
            if (rstH[t & M] || rstH[p1]) begin
                heldAddr = '0;
                heldPix  = '0;
            end else begin
                if (eFetch) heldAddr = 15'((int'(vH[p1]) / 4) * 160 + int'(hH[p1]) / 4);
                else if (eAck) heldAddr = addrH[p1];
                if (fetchH[p2]) heldPix = fvalH[p2];
            end
            if (eFetch) fvalH[t & M] = shadow[heldAddr];
            if (eAck) shadow[addrH[p1]] = dataH[p1];
            eBlank = clean(t - 2, t) && dispH[p2];
            eHs    = clean(t - 2, t) && hsH[p2];
            eVs    = clean(t - 2, t) && vsH[p2];
            eFs    = clean(t - 1, t) && hH[p1] == 16'd0 && vH[p1] == 16'd0;
            ePix   = eBlank ? heldPix : 8'h00;
            checkOutput("m_pixel", 32'(pixel_data), 32'(ePix));
            checkOutput("m_blank", 32'(blank_n), 32'(eBlank));
            checkOutput("m_hsync", 32'(h_sync_out), 32'(eHs));
            checkOutput("m_vsync", 32'(v_sync_out), 32'(eVs));
            checkOutput("m_fstart", 32'(frame_start), 32'(eFs));
            checkOutput("m_we", 32'(mem_we), 32'(eAck));
            checkOutput("m_ack", 32'(wr_ack), 32'(eAck));
            checkOutput("m_err", 32'(wr_err), 32'(eErr));
            checkOutput("m_addr", 32'(mem_addr), 32'(heldAddr));
            if (eAck) checkOutput("m_wdata", 32'(mem_wdata), 32'(dataH[p1]));
        end
        fetchH[t & M] = eFetch;
        ackH[t & M]   = eAck;
        errH[t & M]   = eErr;
        cyc++;
    end

    // Hard bound on run time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int fsCount;

    // Directed sequence with literal expectations at the interesting cycles.
    initial begin
        repeat (4) applyStimulus(1'b1);
        gh = 296; gv = 200;
        repeat (12) applyStimulus(1'b0);

        // Reset mid-frame
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_ack", 32'(wr_ack), 32'd0);
        checkOutput("rst_err", 32'(wr_err), 32'd0);
        checkOutput("rst_pixel", 32'(pixel_data), 32'd0);
        checkOutput("rst_hsync", 32'(h_sync_out), 32'd0);
        checkOutput("rst_vsync", 32'(v_sync_out), 32'd0);
        checkOutput("rst_blank", 32'(blank_n), 32'd0);
        checkOutput("rst_fstart", 32'(frame_start), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        applyStimulus(1'b1);

        // Release at (0,0): fetch of RAM[0]
        gh = 0; gv = 0; prevDisp = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("rel_addr", 32'(mem_addr), 32'd0);
        checkOutput("rel_we", 32'(mem_we), 32'd0);
        checkOutput("rel_fstart", 32'(frame_start), 32'd1);
        applyStimulus(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0);
            checkOutput("rel_pixel", 32'(pixel_data), 32'hE3);
            checkOutput("rel_blank", 32'(blank_n), 32'd1);
        end
        applyStimulus(1'b0);
        checkOutput("rel_pixel1", 32'(pixel_data), 32'h30);

        // Last slot of the active area
        gh = 636; gv = 479;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("last_addr", 32'(mem_addr), 32'd19199);
        checkOutput("last_we", 32'(mem_we), 32'd0);
        repeat (3) applyStimulus(1'b0);
        checkOutput("last_hold", 32'(mem_addr), 32'd19199);

        // Write during vertical blank
        gh = 0; gv = 500;
        wq.push_back({15'd100, 8'h5A});
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("vb_ack", 32'(wr_ack), 32'd1);
        checkOutput("vb_we", 32'(mem_we), 32'd1);
        checkOutput("vb_addr", 32'(mem_addr), 32'd100);
        checkOutput("vb_wdata", 32'(mem_wdata), 32'h5A);
        applyStimulus(1'b0);
        checkOutput("vb_ack_end", 32'(wr_ack), 32'd0);
        gh = 400; gv = 0;
        repeat (4) applyStimulus(1'b0);
        checkOutput("vb_readback", 32'(pixel_data), 32'h5A);

        // Write colliding with a fetch slot at h_pos = 8
        gh = 8; gv = 10;
        wq.push_back({15'd200, 8'hC4});
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("col_fetch_addr", 32'(mem_addr), 32'd322);
        checkOutput("col_fetch_ack", 32'(wr_ack), 32'd0);
        checkOutput("col_fetch_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b0);
        checkOutput("col_wr_ack", 32'(wr_ack), 32'd1);
        checkOutput("col_wr_addr", 32'(mem_addr), 32'd200);
        checkOutput("col_wr_we", 32'(mem_we), 32'd1);
        applyStimulus(1'b0);
        checkOutput("col_pixel", 32'(pixel_data), 32'h95);

        // Out-of-range write
        gh = 0; gv = 505;
        wq.push_back({15'd19200, 8'h77});
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("oor_err", 32'(wr_err), 32'd1);
        checkOutput("oor_ack", 32'(wr_ack), 32'd0);
        checkOutput("oor_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b0);
        checkOutput("oor_err_end", 32'(wr_err), 32'd0);

        // h_sync edge passes through two cycles later
        gh = 650; gv = 100;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            if (i == 7) checkOutput("hs_before", 32'(h_sync_out), 32'd1);
            if (i == 8) checkOutput("hs_after", 32'(h_sync_out), 32'd0);
        end

        // v_sync edge passes through two cycles later
        gh = 796; gv = 489;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0);
            if (i == 5) checkOutput("vs_before", 32'(v_sync_out), 32'd1);
            if (i == 6) checkOutput("vs_after", 32'(v_sync_out), 32'd0);
        end

        // Frame boundary: exactly one frame_start pulse
        gh = 780; gv = 524;
        fsCount = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0);
            if (i >= 1 && frame_start) fsCount++;
        end
        checkOutput("fs_count", 32'(fsCount), 32'd1);

        // Burst of writes across the last active lines, refetched afterwards
        gh = 560; gv = 476;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) wq.push_back({15'd25000, 8'hEE});
            else wq.push_back({15'(19190 + k), 8'(k * 29 + 3)});
        end
        repeat (3300) applyStimulus(1'b0);
        checkOutput("burst_drain", 32'(wq.size()), 32'd0);

        checkOutput("oor_ram", 32'(ram[19200]), 32'h0B);
        checkOutput("vb_ram", 32'(ram[100]), 32'h5A);

        repeat (2) applyStimulus(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
